// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants, transfer encoding and helpers for the elastic pipeline-stage buffer.
// Imported by pipe_stage_ctrl and pipe_stage_buf.
package pipe_stage_buf_pkg;

   localparam int          PIPE_DW_DEF    = 108;
   localparam int          PIPE_DEPTH_DEF = 2;
   localparam logic [31:0] PERF_MAX       = 32'hFFFF_FFFF;

   // {push, pop} pair as seen by the occupancy counter
   typedef enum logic [1:0] {
      XFER_IDLE = 2'b00,
      XFER_POP  = 2'b01,
      XFER_PUSH = 2'b10,
      XFER_BOTH = 2'b11
   } xfer_e;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
      if (en && (value != PERF_MAX)) return value + 32'd1;
      return value;
   endfunction

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Occupancy and pointer control for pipe_stage_buf: push/pop/flush arbitration,
// in_ready from registered count only, out_valid from registered count.
module pipe_stage_ctrl
   import pipe_stage_buf_pkg::*;
#(
   parameter int DEPTH = PIPE_DEPTH_DEF,
   parameter int PW    = ptr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   input  logic          out_ready,
   output logic          in_ready,
   output logic          out_valid,
   output logic          push,
   output logic [PW-1:0] wr_ptr,
   output logic [PW-1:0] rd_ptr
);

   localparam int            CW   = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [CW-1:0] count;
   logic          pop;
   xfer_e         xfer;

   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;
   assign xfer      = xfer_e'({push, pop});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else begin
         case (xfer)
            XFER_PUSH: count <= count + CW'(1);
            XFER_POP:  count <= count - CW'(1);
            default:   count <= count;
         endcase
      end
   end

   // A single-entry stage always reads and writes slot 0
   generate
      if (DEPTH > 1) begin : g_ptr
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
            end else if (flush) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
            end else begin
               if (push) wr_ptr <= wr_ptr + PW'(1);
               if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
         end
      end else begin : g_single
         assign wr_ptr = '0;
         assign rd_ptr = '0;
      end
   endgenerate

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic DEPTH-entry pipeline-stage register with valid/ready handshake and synchronous flush.
// Define MANGOMIPS_PIPE_PERF_EN to enable the saturating stall_cnt / full_cnt counters.
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter int            DW      = PIPE_DW_DEF,
   parameter int            DEPTH   = PIPE_DEPTH_DEF,
   parameter logic [DW-1:0] NOP_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [31:0]   stall_cnt,
   output logic [31:0]   full_cnt
);

   localparam int PW = ptr_width(DEPTH);

   logic          push;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [DW-1:0] mem [DEPTH];

   pipe_stage_ctrl #(
      .DEPTH(DEPTH),
      .PW   (PW)
   ) u_ctrl (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .out_ready(out_ready),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .push     (push),
      .wr_ptr   (wr_ptr),
      .rd_ptr   (rd_ptr)
   );

   // Storage is not reset; out_data masks stale slots with NOP_VAL while empty
   generate
      if (DEPTH > 1) begin : g_mem
         always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= in_data;
         end
         assign out_data = out_valid ? mem[rd_ptr] : NOP_VAL;
      end else begin : g_reg
         always_ff @(posedge clk) begin
            if (push) mem[0] <= in_data;
         end
         assign out_data = out_valid ? mem[0] : NOP_VAL;
      end
   endgenerate

`ifdef MANGOMIPS_PIPE_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] full_q;

   // Counters see raw handshake conditions, so flush cycles count too
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         full_q  <= '0;
      end else begin
         stall_q <= sat_inc(stall_q, out_valid & ~out_ready);
         full_q  <= sat_inc(full_q, in_valid & ~in_ready);
      end
   end

   assign stall_cnt = stall_q;
   assign full_cnt  = full_q;
`else
   assign stall_cnt = 32'h0;
   assign full_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: a DEPTH=2 and a DEPTH=4 instance checked against a queue model.
// Perf counter expectations follow MANGOMIPS_PIPE_PERF_EN.
module tb_pipe_stage_buf;

   localparam logic [15:0] NOP = 16'hDEAD;

   typedef struct {
      logic        iv;
      logic [15:0] d;
      logic        ordy;
      logic        fl;
   } stim_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        flush2 = 1'b0, iv2 = 1'b0, or2 = 1'b0, ir2, ov2;
   logic [15:0] id2 = '0, od2;
   logic [31:0] sc2, fc2;

   logic        flush4 = 1'b0, iv4 = 1'b0, or4 = 1'b0, ir4, ov4;
   logic [15:0] id4 = '0, od4;
   logic [31:0] sc4, fc4;

   logic [15:0] q2[$];
   logic [15:0] q4[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          perf_en;

   always #5 clk = ~clk;

   pipe_stage_buf #(.DW(16), .DEPTH(2), .NOP_VAL(NOP)) dut2 (
      .clk(clk), .rst(rst), .flush(flush2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
      .out_valid(ov2), .out_ready(or2), .out_data(od2), .stall_cnt(sc2), .full_cnt(fc2)
   );

   pipe_stage_buf #(.DW(16), .DEPTH(4), .NOP_VAL(NOP)) dut4 (
      .clk(clk), .rst(rst), .flush(flush4), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
      .out_valid(ov4), .out_ready(or4), .out_data(od4), .stall_cnt(sc4), .full_cnt(fc4)
   );

   task automatic run_table2(input string tag, input stim_t s[$]);
      logic exp_rdy, exp_val;
      foreach (s[i]) begin
         iv2 = s[i].iv; id2 = s[i].d; or2 = s[i].ordy; flush2 = s[i].fl;
         @(negedge clk);
         exp_rdy = (q2.size() != 2);
         exp_val = (q2.size() != 0);
         n_cmp++;
         if (ir2 !== exp_rdy) begin
            n_bad++; $display("[TB] FAIL %s in_ready cyc%0d: got %b want %b", tag, i, ir2, exp_rdy);
         end
         n_cmp++;
         if (ov2 !== exp_val) begin
            n_bad++; $display("[TB] FAIL %s out_valid cyc%0d: got %b want %b", tag, i, ov2, exp_val);
         end
         n_cmp++;
         if (od2 !== (exp_val ? q2[0] : NOP)) begin
            n_bad++; $display("[TB] FAIL %s out_data cyc%0d: got %h want %h", tag, i, od2, exp_val ? q2[0] : NOP);
         end
         if (flush2) q2.delete();
         else begin
            if (exp_val && or2) void'(q2.pop_front());
            if (iv2 && exp_rdy) q2.push_back(id2);
         end
         @(posedge clk); #1;
      end
      iv2 = 1'b0; or2 = 1'b0; flush2 = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++;
      if (ov2 !== 1'b0 || od2 !== NOP || ir2 !== 1'b1) begin
         n_bad++; $display("[TB] FAIL reset_init: got v=%b d=%h r=%b want v=0 d=%h r=1", ov2, od2, ir2, NOP);
      end
      iv2 = 1'b1; id2 = 16'h0001; or2 = 1'b0;
      @(posedge clk); #1;
      id2 = 16'h0002;
      @(posedge clk); #1;
      iv2 = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ov2 !== 1'b1 || ir2 !== 1'b0) begin
         n_bad++; $display("[TB] FAIL reset_prefill: got v=%b r=%b want v=1 r=0", ov2, ir2);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (ov2 !== 1'b0 || od2 !== NOP || ir2 !== 1'b1) begin
         n_bad++; $display("[TB] FAIL reset_async: got v=%b d=%h r=%b want v=0 d=%h r=1", ov2, od2, ir2, NOP);
      end
      n_cmp++;
      if (sc2 !== 32'h0 || fc2 !== 32'h0) begin
         n_bad++; $display("[TB] FAIL reset_perf: got stall=%0d full=%0d want 0", sc2, fc2);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      q2.delete();
      q4.delete();
   endtask

   task automatic test_streaming();
      stim_t s[$] = '{'{1'b1, 16'h0011, 1'b1, 1'b0}, '{1'b1, 16'h0022, 1'b1, 1'b0},
                      '{1'b1, 16'h0033, 1'b1, 1'b0}, '{1'b0, 16'h0000, 1'b1, 1'b0},
                      '{1'b0, 16'h0000, 1'b1, 1'b0}};
      run_table2("stream", s);
   endtask

   task automatic test_backpressure();
      stim_t s[$] = '{'{1'b1, 16'h000A, 1'b0, 1'b0}, '{1'b1, 16'h000B, 1'b0, 1'b0},
                      '{1'b1, 16'h000C, 1'b0, 1'b0}, '{1'b1, 16'h000C, 1'b0, 1'b0},
                      '{1'b1, 16'h000C, 1'b0, 1'b0}, '{1'b1, 16'h000C, 1'b1, 1'b0},
                      '{1'b1, 16'h000C, 1'b1, 1'b0}, '{1'b0, 16'h0000, 1'b1, 1'b0},
                      '{1'b0, 16'h0000, 1'b1, 1'b0}};
      run_table2("backpressure", s);
   endtask

   task automatic test_flush();
      stim_t s[$] = '{'{1'b1, 16'h0044, 1'b0, 1'b0}, '{1'b1, 16'h0055, 1'b0, 1'b0},
                      '{1'b1, 16'h0066, 1'b1, 1'b1}, '{1'b0, 16'h0000, 1'b1, 1'b0},
                      '{1'b1, 16'h0077, 1'b0, 1'b0}, '{1'b1, 16'h0088, 1'b1, 1'b1},
                      '{1'b0, 16'h0000, 1'b1, 1'b1}, '{1'b1, 16'h0099, 1'b1, 1'b0},
                      '{1'b0, 16'h0000, 1'b1, 1'b0}, '{1'b0, 16'h0000, 1'b1, 1'b0}};
      run_table2("flush", s);
   endtask

   task automatic test_wrap();
      int   pushed = 0;
      logic exp_rdy, exp_val;
      for (int cyc = 0; cyc < 300 && !(pushed == 10 && q4.size() == 0); cyc++) begin
         iv4 = (pushed < 10); id4 = 16'h0100 + 16'(pushed); or4 = 1'($urandom_range(0, 1));
         @(negedge clk);
         exp_rdy = (q4.size() != 4);
         exp_val = (q4.size() != 0);
         n_cmp++;
         if (ir4 !== exp_rdy || ov4 !== exp_val) begin
            n_bad++; $display("[TB] FAIL wrap_flags cyc%0d: got r=%b v=%b want r=%b v=%b", cyc, ir4, ov4, exp_rdy, exp_val);
         end
         n_cmp++;
         if (od4 !== (exp_val ? q4[0] : NOP)) begin
            n_bad++; $display("[TB] FAIL wrap_data cyc%0d: got %h want %h", cyc, od4, exp_val ? q4[0] : NOP);
         end
         if (exp_val && or4) void'(q4.pop_front());
         if (iv4 && exp_rdy) begin
            q4.push_back(id4);
            pushed++;
         end
         @(posedge clk); #1;
      end
      iv4 = 1'b0; or4 = 1'b0;
      n_cmp++;
      if (pushed != 10 || q4.size() != 0) begin
         n_bad++; $display("[TB] FAIL wrap_timeout: got pushed=%0d left=%0d want 10/0", pushed, q4.size());
      end
   endtask

   task automatic test_perf();
      stim_t s[$] = '{'{1'b1, 16'h00C1, 1'b0, 1'b0}, '{1'b0, 16'h0000, 1'b0, 1'b0},
                      '{1'b0, 16'h0000, 1'b0, 1'b0}, '{1'b0, 16'h0000, 1'b0, 1'b0},
                      '{1'b0, 16'h0000, 1'b0, 1'b0}, '{1'b0, 16'h0000, 1'b0, 1'b0},
                      '{1'b0, 16'h0000, 1'b1, 1'b1}, '{1'b1, 16'h00C2, 1'b0, 1'b0},
                      '{1'b1, 16'h00C3, 1'b0, 1'b0}, '{1'b1, 16'h00C4, 1'b0, 1'b0},
                      '{1'b1, 16'h00C4, 1'b0, 1'b1}, '{1'b0, 16'h0000, 1'b1, 1'b0}};
      int   exp_stall = 0, exp_full = 0;
      logic exp_rdy, exp_val;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      q2.delete();
      foreach (s[i]) begin
         iv2 = s[i].iv; id2 = s[i].d; or2 = s[i].ordy; flush2 = s[i].fl;
         @(negedge clk);
         exp_rdy = (q2.size() != 2);
         exp_val = (q2.size() != 0);
         n_cmp++;
         if (sc2 !== (perf_en ? 32'(exp_stall) : 32'h0)) begin
            n_bad++; $display("[TB] FAIL perf_stall cyc%0d: got %0d want %0d", i, sc2, perf_en ? exp_stall : 0);
         end
         n_cmp++;
         if (fc2 !== (perf_en ? 32'(exp_full) : 32'h0)) begin
            n_bad++; $display("[TB] FAIL perf_full cyc%0d: got %0d want %0d", i, fc2, perf_en ? exp_full : 0);
         end
         n_cmp++;
         if (ov2 !== exp_val || od2 !== (exp_val ? q2[0] : NOP)) begin
            n_bad++; $display("[TB] FAIL perf_out cyc%0d: got v=%b d=%h want v=%b", i, ov2, od2, exp_val);
         end
         if (exp_val && !or2) exp_stall++;
         if (iv2 && !exp_rdy) exp_full++;
         if (flush2) q2.delete();
         else begin
            if (exp_val && or2) void'(q2.pop_front());
            if (iv2 && exp_rdy) q2.push_back(id2);
         end
         @(posedge clk); #1;
      end
      iv2 = 1'b0; or2 = 1'b0; flush2 = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (sc2 !== 32'h0 || fc2 !== 32'h0) begin
         n_bad++; $display("[TB] FAIL perf_rst: got stall=%0d full=%0d want 0", sc2, fc2);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
`ifdef MANGOMIPS_PIPE_PERF_EN
      perf_en = 1'b1;
`else
      perf_en = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_wrap();
      test_perf();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
